execute_stage: RTL and testbench
================================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 clk  in  1  rising-edge clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-002 regwriteE, memrwE, brunE, branchE, jumpE, bselE  in  1 each  decoded E-stage controls.
REQ-003 wbselE  in  2  writeback select; aluselE  in  3  ALU op; funct3E  in  3  branch condition.
REQ-004 rdE, rs1E, rs2E  in  5 each  register indices; rd1E, rd2E, imm_exE, pcE, pc4E  in  32 each.
REQ-005 forwardAE, forwardBE  in  2 each  operand source (00 register, 01 resultW, 10 aluresultM, 11 reserved).
REQ-006 resultW  in  32  writeback-stage result.
REQ-007 breqE, brltE  out  1 each  comparator outputs (combinational).
REQ-008 pcselE  out  1  redirect fetch (combinational); pctargetE  out  32  redirect address (combinational).
REQ-009 regwriteM, memrwM  out  1; wbselM  out  2; rdM  out  5; aluresultM, writedataM, pc4M  out  32 (registered).

Function
REQ-010 srcA = rd1E / resultW / aluresultM for forwardAE 00 / 01 / 10; code 11 selects rd1E.
REQ-011 fwdB uses the same rule on rd2E with forwardBE; srcB = bselE ? imm_exE : fwdB.
REQ-012 ALU, 32-bit wrap-around: 000 add, 001 sub (srcA-srcB), 010 and, 011 or, 100 xor; other codes add.
REQ-013 breqE = (srcA == fwdB); brltE = brunE ? unsigned(srcA < fwdB) : signed(srcA < fwdB).
REQ-014 taken = branchE and (funct3 000: breqE; 001: !breqE; 100: brltE; 101: !brltE; other: 0).
REQ-015 pcselE = taken or jumpE, same cycle as inputs, no latency.
REQ-016 pctargetE = (srcA + imm_exE) with bit0 cleared when jumpE and bselE (jalr); otherwise pcE + imm_exE.
REQ-017 On each rising edge, the EX/MEM register captures: regwriteE, memrwE, wbselE, rdE, ALU result, fwdB (as writedataM), and pc4E; 1-cycle latency.
REQ-018 The aluresultM fed back via forward code 10 is the current registered value, never the combinational result.
REQ-019 A flushed bubble (all-zero inputs) propagates as regwriteM=0, memrwM=0, no other side effect.
REQ-020 If forwardAE and forwardBE both select the same source, both operands use it; no priority conflict exists.

Reset
REQ-021 rst_n low immediately clears all registered outputs to 0, including mid-operation.
REQ-022 While rst_n is low, combinational outputs follow their inputs.
REQ-023 The first edge after release captures normally.

Configuration
REQ-024 When macro EXECUTE_SLT_EN is defined, aluselE 101 = slt (signed, result 0/1) and 110 = sltu (unsigned).
REQ-025 Without EXECUTE_SLT_EN, aluselE 101 and 110 perform add per REQ-012.
REQ-026 EXECUTE_SLT_EN changes no port and no other behaviour.

Verification
REQ-027 add: rd1E=5, rd2E=7, aluselE=000, bselE=0, rdE=3, regwriteE=1 -> next edge aluresultM=12, rdM=3, regwriteM=1.
REQ-028 forwarding: forwardAE=10 with aluresultM=0x10; forwardBE=01 with resultW=0x3; aluselE=001 -> next aluresultM=0xD.
REQ-029 blt: branchE=1, funct3=100, srcA=0xFFFFFFFF, fwdB=1 -> brltE=1, pcselE=1 when brunE=0; brltE=0, pcselE=0 when brunE=1.
REQ-030 jalr: jumpE=1, bselE=1, srcA=0x1001, imm=4 -> pctargetE=0x1004, pcselE=1; pc4E=0x208 -> pc4M=0x208.
REQ-031 reset: registered outputs nonzero, assert rst_n low between edges -> all registered outputs 0 immediately.
REQ-032 slt: srcA=-2, imm=1, bselE=1, aluselE=101 -> aluresultM=1 with EXECUTE_SLT_EN, 0xFFFFFFFF without it.

Source files
------------

// File: rtl/execute_stage_if.sv
// E-stage decoded controls and operands in, comparator/redirect and EX/MEM register out.
// Pure signal bundle: no logic and no latency of its own.
// No backpressure: the stage consumes one instruction per cycle.
interface execute_stage_if;
    logic        regwriteE;
    logic        memrwE;
    logic        brunE;
    logic        branchE;
    logic        jumpE;
    logic        bselE;
    logic [1:0]  wbselE;
    logic [2:0]  aluselE;
    logic [2:0]  funct3E;
    logic [4:0]  rdE;
    logic [4:0]  rs1E;
    logic [4:0]  rs2E;
    logic [31:0] rd1E;
    logic [31:0] rd2E;
    logic [31:0] imm_exE;
    logic [31:0] pcE;
    logic [31:0] pc4E;
    logic [1:0]  forwardAE;
    logic [1:0]  forwardBE;
    logic [31:0] resultW;

    logic        breqE;
    logic        brltE;
    logic        pcselE;
    logic [31:0] pctargetE;
    logic        regwriteM;
    logic        memrwM;
    logic [1:0]  wbselM;
    logic [4:0]  rdM;
    logic [31:0] aluresultM;
    logic [31:0] writedataM;
    logic [31:0] pc4M;

    modport master (
        output regwriteE, memrwE, brunE, branchE, jumpE, bselE, wbselE, aluselE, funct3E,
               rdE, rs1E, rs2E, rd1E, rd2E, imm_exE, pcE, pc4E, forwardAE, forwardBE, resultW,
        input  breqE, brltE, pcselE, pctargetE,
               regwriteM, memrwM, wbselM, rdM, aluresultM, writedataM, pc4M
    );

    modport slave (
        input  regwriteE, memrwE, brunE, branchE, jumpE, bselE, wbselE, aluselE, funct3E,
               rdE, rs1E, rs2E, rd1E, rd2E, imm_exE, pcE, pc4E, forwardAE, forwardBE, resultW,
        output breqE, brltE, pcselE, pctargetE,
               regwriteM, memrwM, wbselM, rdM, aluresultM, writedataM, pc4M
    );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: forwarding muxes, ALU, branch compare/redirect, EX/MEM register (EXECUTE_SLT_EN adds slt/sltu).
// Latency: redirect outputs combinational; EX/MEM outputs 1 cycle.
// No backpressure: stalls/flushes are applied upstream as bubbles.
module execute_stage (
    input  logic         clk,
    input  logic         rst_n,
    execute_stage_if.slave ex
);

    typedef struct packed {
        logic        regwrite;
        logic        memrw;
        logic [1:0]  wbsel;
        logic [4:0]  rd;
        logic [31:0] aluresult;
        logic [31:0] writedata;
        logic [31:0] pc4;
    } exMemT;

    exMemT       exMemQ;
    logic [31:0] srcA;
    logic [31:0] fwdB;
    logic [31:0] srcB;
    logic [31:0] aluResult;
    logic [31:0] jalrSum;
    logic        taken;

    // Forward code 10 must use the registered M-stage value, not this cycle's ALU output.
    always_comb begin
        srcA = ex.rd1E;
        case (ex.forwardAE)
            2'b01:   srcA = ex.resultW;
            2'b10:   srcA = exMemQ.aluresult;
            default: srcA = ex.rd1E;
        endcase
        fwdB = ex.rd2E;
        case (ex.forwardBE)
            2'b01:   fwdB = ex.resultW;
            2'b10:   fwdB = exMemQ.aluresult;
            default: fwdB = ex.rd2E;
        endcase
    end

    assign srcB = ex.bselE ? ex.imm_exE : fwdB;

    always_comb begin
        aluResult = srcA + srcB;
        case (ex.aluselE)
            3'b001:  aluResult = srcA - srcB;
            3'b010:  aluResult = srcA & srcB;
            3'b011:  aluResult = srcA | srcB;
            3'b100:  aluResult = srcA ^ srcB;
`ifdef EXECUTE_SLT_EN
            3'b101:  aluResult = {31'd0, $signed(srcA) < $signed(srcB)};
            3'b110:  aluResult = {31'd0, srcA < srcB};
`endif
            default: aluResult = srcA + srcB;
        endcase
    end

    assign ex.breqE = (srcA == fwdB);
    assign ex.brltE = ex.brunE ? (srcA < fwdB) : ($signed(srcA) < $signed(fwdB));

    always_comb begin
        taken = 1'b0;
        if (ex.branchE) begin
            case (ex.funct3E)
                3'b000:  taken = ex.breqE;
                3'b001:  taken = !ex.breqE;
                3'b100:  taken = ex.brltE;
                3'b101:  taken = !ex.brltE;
                default: taken = 1'b0;
            endcase
        end
    end

    assign ex.pcselE    = taken | ex.jumpE;
    assign jalrSum      = srcA + ex.imm_exE;
    assign ex.pctargetE = (ex.jumpE && ex.bselE) ? {jalrSum[31:1], 1'b0} : (ex.pcE + ex.imm_exE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exMemQ <= '0;
        end else begin
            exMemQ.regwrite  <= ex.regwriteE;
            exMemQ.memrw     <= ex.memrwE;
            exMemQ.wbsel     <= ex.wbselE;
            exMemQ.rd        <= ex.rdE;
            exMemQ.aluresult <= aluResult;
            exMemQ.writedata <= fwdB;
            exMemQ.pc4       <= ex.pc4E;
        end
    end

    assign ex.regwriteM  = exMemQ.regwrite;
    assign ex.memrwM     = exMemQ.memrw;
    assign ex.wbselM     = exMemQ.wbsel;
    assign ex.rdM        = exMemQ.rd;
    assign ex.aluresultM = exMemQ.aluresult;
    assign ex.writedataM = exMemQ.writedata;
    assign ex.pc4M       = exMemQ.pc4;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: forwarding, ALU ops, branch/jump redirect, async reset.
// Inputs change on the falling edge; outputs are sampled #1 after an edge or input change.
module tb_execute_stage;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    execute_stage_if exIf();

    execute_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ex    (exIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clearInputs();
        exIf.regwriteE = 0; exIf.memrwE = 0; exIf.brunE = 0; exIf.branchE = 0;
        exIf.jumpE = 0; exIf.bselE = 0; exIf.wbselE = 0; exIf.aluselE = 0;
        exIf.funct3E = 0; exIf.rdE = 0; exIf.rs1E = 0; exIf.rs2E = 0;
        exIf.rd1E = 0; exIf.rd2E = 0; exIf.imm_exE = 0; exIf.pcE = 0; exIf.pc4E = 0;
        exIf.forwardAE = 0; exIf.forwardBE = 0; exIf.resultW = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nextSlot();
        @(negedge clk);
        clearInputs();
    endtask

    task automatic checkRegsZero(input string tag);
        check({tag, ".regwriteM"},  {31'd0, exIf.regwriteM}, 32'd0);
        check({tag, ".memrwM"},     {31'd0, exIf.memrwM},    32'd0);
        check({tag, ".wbselM"},     {30'd0, exIf.wbselM},    32'd0);
        check({tag, ".rdM"},        {27'd0, exIf.rdM},       32'd0);
        check({tag, ".aluresultM"}, exIf.aluresultM,         32'd0);
        check({tag, ".writedataM"}, exIf.writedataM,         32'd0);
        check({tag, ".pc4M"},       exIf.pc4M,               32'd0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        clearInputs();
        repeat (2) @(posedge clk);
        #1;
        checkRegsZero("reset");

        // Plain add
        @(negedge clk);
        rst_n = 1'b1;
        exIf.rd1E = 5; exIf.rd2E = 7; exIf.rdE = 3; exIf.regwriteE = 1;
        exIf.wbselE = 2'b01; exIf.pc4E = 32'h104;
        #1;
        check("add.breqE", {31'd0, exIf.breqE}, 32'd0);
        check("add.brltE", {31'd0, exIf.brltE}, 32'd1);
        tick();
        check("add.aluresultM", exIf.aluresultM, 32'd12);
        check("add.rdM",        {27'd0, exIf.rdM}, 32'd3);
        check("add.regwriteM",  {31'd0, exIf.regwriteM}, 32'd1);
        check("add.writedataM", exIf.writedataM, 32'd7);
        check("add.wbselM",     {30'd0, exIf.wbselM}, 32'd1);
        check("add.pc4M",       exIf.pc4M, 32'h104);

        // Prime aluresultM = 0x10, then forward it (A) and resultW (B) into a sub
        nextSlot();
        exIf.rd1E = 8; exIf.rd2E = 8;
        tick();
        check("prime.aluresultM", exIf.aluresultM, 32'h10);
        nextSlot();
        exIf.forwardAE = 2'b10; exIf.forwardBE = 2'b01; exIf.resultW = 32'h3;
        exIf.rd1E = 32'hAAAA; exIf.rd2E = 32'h5555; exIf.aluselE = 3'b001;
        #1;
        check("fwd.breqE", {31'd0, exIf.breqE}, 32'd0);
        check("fwd.brltE", {31'd0, exIf.brltE}, 32'd0);
        tick();
        check("fwd.aluresultM", exIf.aluresultM, 32'hD);
        check("fwd.writedataM", exIf.writedataM, 32'h3);

        // Reserved code 11 selects the register value
        nextSlot();
        exIf.forwardAE = 2'b11; exIf.rd1E = 9; exIf.rd2E = 4; exIf.aluselE = 3'b001;
        exIf.resultW = 32'h77;
        tick();
        check("fwd11.aluresultM", exIf.aluresultM, 32'd5);

        // Both operands from resultW
        nextSlot();
        exIf.forwardAE = 2'b01; exIf.forwardBE = 2'b01; exIf.resultW = 32'h6;
        exIf.rd1E = 32'hF0; exIf.rd2E = 32'h0F; exIf.aluselE = 3'b010;
        #1;
        check("same.breqE", {31'd0, exIf.breqE}, 32'd1);
        tick();
        check("same.aluresultM", exIf.aluresultM, 32'h6);

        // Immediate operand: or, xor, wrap-around add, unused code adds
        nextSlot();
        exIf.bselE = 1; exIf.rd1E = 32'hF0; exIf.imm_exE = 32'h0F; exIf.rd2E = 32'h1234;
        exIf.aluselE = 3'b011;
        tick();
        check("or.aluresultM", exIf.aluresultM, 32'hFF);
        check("or.writedataM", exIf.writedataM, 32'h1234);
        nextSlot();
        exIf.bselE = 1; exIf.rd1E = 32'hFF00FF00; exIf.imm_exE = 32'h0FF00FF0; exIf.aluselE = 3'b100;
        tick();
        check("xor.aluresultM", exIf.aluresultM, 32'hF0F0F0F0);
        nextSlot();
        exIf.bselE = 1; exIf.rd1E = 32'hFFFFFFFF; exIf.imm_exE = 32'd2;
        tick();
        check("wrap.aluresultM", exIf.aluresultM, 32'd1);
        nextSlot();
        exIf.rd1E = 3; exIf.rd2E = 4; exIf.aluselE = 3'b111;
        tick();
        check("op111.aluresultM", exIf.aluresultM, 32'd7);

        // blt signed vs unsigned
        nextSlot();
        exIf.branchE = 1; exIf.funct3E = 3'b100; exIf.rd1E = 32'hFFFFFFFF; exIf.rd2E = 1;
        exIf.pcE = 32'h100; exIf.imm_exE = 32'h20;
        #1;
        check("blt.brltE",     {31'd0, exIf.brltE},  32'd1);
        check("blt.pcselE",    {31'd0, exIf.pcselE}, 32'd1);
        check("blt.pctargetE", exIf.pctargetE, 32'h120);
        exIf.brunE = 1;
        #1;
        check("bltu.brltE",  {31'd0, exIf.brltE},  32'd0);
        check("bltu.pcselE", {31'd0, exIf.pcselE}, 32'd0);
        exIf.funct3E = 3'b101;
        #1;
        check("bgeu.pcselE", {31'd0, exIf.pcselE}, 32'd1);
        exIf.rd2E = 32'hFFFFFFFF; exIf.funct3E = 3'b000;
        #1;
        check("beq.pcselE", {31'd0, exIf.pcselE}, 32'd1);
        exIf.funct3E = 3'b001;
        #1;
        check("bne.pcselE", {31'd0, exIf.pcselE}, 32'd0);
        exIf.funct3E = 3'b010;
        #1;
        check("f3_010.pcselE", {31'd0, exIf.pcselE}, 32'd0);
        exIf.branchE = 0; exIf.funct3E = 3'b000;
        #1;
        check("nobranch.pcselE", {31'd0, exIf.pcselE}, 32'd0);

        // jalr clears bit 0; jal uses pcE
        nextSlot();
        exIf.jumpE = 1; exIf.bselE = 1; exIf.rd1E = 32'h1001; exIf.imm_exE = 4;
        exIf.pcE = 32'h200; exIf.pc4E = 32'h208; exIf.regwriteE = 1; exIf.rdE = 1;
        #1;
        check("jalr.pctargetE", exIf.pctargetE, 32'h1004);
        check("jalr.pcselE",    {31'd0, exIf.pcselE}, 32'd1);
        tick();
        check("jalr.pc4M",       exIf.pc4M, 32'h208);
        check("jalr.aluresultM", exIf.aluresultM, 32'h1005);
        nextSlot();
        exIf.jumpE = 1; exIf.pcE = 32'h300; exIf.imm_exE = 32'h11; exIf.rd1E = 32'h5000;
        #1;
        check("jal.pctargetE", exIf.pctargetE, 32'h311);
        check("jal.pcselE",    {31'd0, exIf.pcselE}, 32'd1);

        // Flushed bubble
        nextSlot();
        tick();
        check("bubble.regwriteM", {31'd0, exIf.regwriteM}, 32'd0);
        check("bubble.memrwM",    {31'd0, exIf.memrwM},    32'd0);
        check("bubble.aluresultM", exIf.aluresultM, 32'd0);

        // slt / sltu: -2 vs 1
        nextSlot();
        exIf.bselE = 1; exIf.rd1E = 32'hFFFFFFFE; exIf.imm_exE = 1; exIf.aluselE = 3'b101;
        tick();
`ifdef EXECUTE_SLT_EN
        check("slt.aluresultM", exIf.aluresultM, 32'd1);
`else
        check("slt.aluresultM", exIf.aluresultM, 32'hFFFFFFFF);
`endif
        nextSlot();
        exIf.bselE = 1; exIf.rd1E = 32'hFFFFFFFE; exIf.imm_exE = 1; exIf.aluselE = 3'b110;
        tick();
`ifdef EXECUTE_SLT_EN
        check("sltu.aluresultM", exIf.aluresultM, 32'd0);
`else
        check("sltu.aluresultM", exIf.aluresultM, 32'hFFFFFFFF);
`endif

        // Asynchronous reset between edges
        nextSlot();
        exIf.regwriteE = 1; exIf.memrwE = 1; exIf.wbselE = 2'b10; exIf.rdE = 9;
        exIf.rd1E = 32'h11; exIf.rd2E = 32'h22; exIf.pc4E = 32'h44;
        tick();
        check("pre.regwriteM",  {31'd0, exIf.regwriteM}, 32'd1);
        check("pre.memrwM",     {31'd0, exIf.memrwM},    32'd1);
        check("pre.aluresultM", exIf.aluresultM, 32'h33);
        #2;
        rst_n = 1'b0;
        #1;
        checkRegsZero("async");
        nextSlot();
        exIf.jumpE = 1; exIf.pcE = 32'h40; exIf.imm_exE = 32'h8;
        #1;
        check("inreset.pcselE",    {31'd0, exIf.pcselE}, 32'd1);
        check("inreset.pctargetE", exIf.pctargetE, 32'h48);
        tick();
        check("inreset.regwriteM", {31'd0, exIf.regwriteM}, 32'd0);

        // First edge after release captures
        nextSlot();
        rst_n = 1'b1;
        exIf.regwriteE = 1; exIf.rdE = 7; exIf.rd1E = 1; exIf.rd2E = 2;
        tick();
        check("release.aluresultM", exIf.aluresultM, 32'd3);
        check("release.rdM",        {27'd0, exIf.rdM}, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
